audio_pdm_dac: RTL and testbench

Output stage of the PET audio path: accepts signed PCM samples from the audio synthesizer over a valid/ready handshake and buffers them in a small FIFO. Samples are consumed at a fixed rate derived from `clk16_i`, and each one is converted to a 1-bit first-order delta-sigma (PDM) stream that drives the board's RC-filtered audio pin. On FIFO underrun the block repeats the last sample and raises a sticky flag.

---
 rtl/audio_pdm_dac.sv | 108 ++++++++++
 tb/tb_audio_pdm_dac.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pdm_dac.sv
// PCM sample FIFO feeding a first-order delta-sigma (PDM) modulator for the audio pin.
// Optional LFSR dither on the modulator carry-in is enabled by defining AUDIO_PDM_DITHER_EN.
module audio_pdm_dac #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_DIV = 16
) (
  input  logic             clk16_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  input  logic             clear_underrun_i,
  output logic             underrun_o,
  output logic             audio_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [TW-1:0]    tick;
  logic [WIDTH-1:0] cur_sample;
  logic [WIDTH-1:0] acc;
  logic             armed;

  logic             full, empty, push, pop_tick, pop, set_underrun;
  logic [WIDTH-1:0] u;
  logic [WIDTH:0]   sum;
  logic             cin;

  assign full           = (count == (AW+1)'(FIFO_DEPTH));
  assign empty          = (count == '0);
  assign sample_ready_o = ~full;
  assign push           = sample_valid_i & ~full;
  assign pop_tick       = (tick == TW'(SAMPLE_DIV - 1));
  // An empty FIFO on the pop tick means the pop sees nothing, even if a push lands this same edge.
  assign pop            = pop_tick & ~empty;
  assign set_underrun   = pop_tick & empty & armed;

  // NOTE: FIFO storage has no reset; validity is tracked by count, so clearing it would only cost flops.
  always_ff @(posedge clk16_i) begin
    if (push) mem[wr_ptr] <= sample_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tick       <= '0;
      cur_sample <= '0;
      armed      <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      tick <= pop_tick ? '0 : tick + TW'(1);
      if (pop)  cur_sample <= mem[rd_ptr];
      if (push) armed <= 1'b1;
      // A set on the same edge as a clear takes priority.
      if (set_underrun)          underrun_o <= 1'b1;
      else if (clear_underrun_i) underrun_o <= 1'b0;
    end
  end

`ifdef AUDIO_PDM_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk16_i or negedge reset_n_i) begin
    if (!reset_n_i) lfsr <= 16'hACE1;
    else            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign cin = lfsr[0];
`else
  assign cin = 1'b0;
`endif

  // Offset binary: signed midscale maps to 50% ones density.
  assign u   = cur_sample ^ {1'b1, {(WIDTH-1){1'b0}}};
  assign sum = {1'b0, acc} + {1'b0, u} + {{WIDTH{1'b0}}, cin};

  always_ff @(posedge clk16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc     <= '0;
      audio_o <= 1'b0;
    end else begin
      acc     <= sum[WIDTH-1:0];
      audio_o <= sum[WIDTH];
    end
  end

endmodule

// File: tb/tb_audio_pdm_dac.sv
// Self-checking bench for audio_pdm_dac: directed vector tables, hand-derived corner sequences,
// and randomized traffic compared cycle by cycle against a cumulative-sum reference model.
module tb_audio_pdm_dac;

  localparam int W   = 16;
  localparam int DEP = 4;
  localparam int DIV = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sample = '0;
  logic         valid = 1'b0;
  logic         clear = 1'b0;
  logic         ready, und, audio;

  audio_pdm_dac #(.WIDTH(W), .FIFO_DEPTH(DEP), .SAMPLE_DIV(DIV)) dut (
    .clk16_i          (clk),
    .reset_n_i        (reset_n),
    .sample_i         (sample),
    .sample_valid_i   (valid),
    .sample_ready_o   (ready),
    .clear_underrun_i (clear),
    .underrun_o       (und),
    .audio_o          (audio)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int ones  = 0;

  // Reference model: FIFO as a queue, pop schedule as a cycle number, and the PDM stream
  // derived from the running total of offset-binary samples (each 2^W crossing emits a one).
  logic [W-1:0]    m_q[$];
  int              m_tick;
  logic [W-1:0]    m_cur;
  bit              m_armed, m_und, m_audio;
  longint unsigned m_s;

  typedef struct {
    bit           valid;
    logic [W-1:0] sample;
    bit           clear;
    bit           exp_ready;
    bit           exp_und;
    bit           exp_audio;
  } vec_t;

  vec_t t_idle[12];
  vec_t t_full[18];

  task automatic check(input string name, input longint actual, input longint expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_tick  = 0;
    m_cur   = '0;
    m_armed = 0;
    m_und   = 0;
    m_s     = 0;
  endtask

  task automatic step();
    bit              empty0, push, poptick, set;
    longint unsigned uu;
    empty0  = (m_q.size() == 0);
    push    = valid && (m_q.size() < DEP);
    poptick = (m_tick == DIV - 1);
    uu      = longint'(m_cur ^ 16'h8000);
    m_audio = ((m_s + uu) >> W) != (m_s >> W);
    m_s     = m_s + uu;
    set     = poptick && empty0 && m_armed;
    if (poptick && !empty0) m_cur = m_q.pop_front();
    if (set)        m_und = 1;
    else if (clear) m_und = 0;
    if (push) begin
      m_q.push_back(sample);
      m_armed = 1;
    end
    m_tick = (m_tick + 1) % DIV;
    @(posedge clk);
    #1;
    ones += int'(audio);
    check("model_audio", audio, m_audio);
    check("model_ready", ready, (m_q.size() < DEP));
    check("model_underrun", und, m_und);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid   = 1'b0;
    clear   = 1'b0;
    #1;
    check("rst_audio", audio, 0);
    check("rst_ready", ready, 1);
    check("rst_underrun", und, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic run_until_tick(input int t);
    for (int i = 0; i < DIV && m_tick != t; i++) step();
  endtask

  task automatic push_one(input logic [W-1:0] d);
    valid  = 1'b1;
    sample = d;
    step();
    valid  = 1'b0;
  endtask

  initial begin
    // Idle after reset: 50% pattern starting with 0, always ready, never underrun.
    for (int k = 0; k < 12; k++)
      t_idle[k] = '{valid: 0, sample: 16'h0, clear: 0, exp_ready: 1, exp_und: 0, exp_audio: bit'(k & 1)};

    // Back-to-back pushes: four fill the FIFO, junk is offered while ready is low, the first
    // pop (edge 15) frees a slot and sample 5 enters on edge 16.
    for (int k = 0; k < 18; k++) begin
      t_full[k].valid     = 1;
      t_full[k].clear     = 0;
      t_full[k].exp_und   = 0;
      t_full[k].exp_audio = bit'(k & 1);
      t_full[k].exp_ready = (k < 3) || (k == 15);
      t_full[k].sample    = 16'h0F00 + 16'(k);
    end
    t_full[0].sample  = 16'h7FFF;
    t_full[1].sample  = 16'h8000;
    t_full[2].sample  = 16'h1234;
    t_full[3].sample  = 16'hC000;
    t_full[16].sample = 16'h5A5A;
    t_full[17].sample = 16'h2222;

    // Reset pattern and unarmed idle.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      valid = t_idle[k].valid; sample = t_idle[k].sample; clear = t_idle[k].clear;
      step();
      check("idle_audio", audio, t_idle[k].exp_audio);
      check("idle_ready", ready, t_idle[k].exp_ready);
      check("idle_underrun", und, t_idle[k].exp_und);
    end
    repeat (10 * DIV) step();
    check("idle_not_armed", und, 0);

    // Full FIFO back-pressure, then drain into underrun.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      valid = t_full[k].valid; sample = t_full[k].sample; clear = t_full[k].clear;
      step();
      check("full_audio", audio, t_full[k].exp_audio);
      check("full_ready", ready, t_full[k].exp_ready);
      check("full_underrun", und, t_full[k].exp_und);
    end
    valid = 1'b0;
    repeat (100) step();
    check("drain_underrun", und, 1);

    // Extremes: full-scale positive yields one zero per 2^W cycles, full-scale negative none.
    do_reset();
    push_one(16'h7FFF);
    repeat (15) step();
    ones = 0;
    repeat (4096) step();
    check("ones_7fff", ones, 4095);
    push_one(16'h8000);
    for (int i = 0; i < 4 * DIV && m_q.size() != 0; i++) step();
    ones = 0;
    repeat (4096) step();
    check("ones_8000", ones, 0);

    // Underrun: one sample, second pop finds the FIFO empty.
    do_reset();
    push_one(16'h4000);
    repeat (31) step();
    check("und_after_2nd_pop", und, 1);
    ones = 0;
    repeat (4096) step();
    check("ones_c000", ones, 3072);
    run_until_tick(4);
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_non_pop", und, 0);
    run_until_tick(15);
    step();
    check("reset_on_pop", und, 1);
    run_until_tick(15);
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_on_pop_loses", und, 1);

    // Push/pop collision on an empty, armed FIFO.
    run_until_tick(3);
    clear = 1'b1; step(); clear = 1'b0;
    check("collide_pre_clear", und, 0);
    run_until_tick(15);
    push_one(16'h7FFF);
    check("collide_underrun", und, 1);
    check("collide_queued", int'(m_q.size()), 1);
    repeat (15) step();
    check("collide_still_queued", ready, 1);
    step();
    ones = 0;
    repeat (64) step();
    check("collide_popped_density", ones >= 63, 1);

    // Asynchronous reset with samples queued.
    push_one(16'h7FFF);
    push_one(16'h7FFF);
    push_one(16'h7FFF);
    for (int i = 0; i < 8 && audio != 1'b1; i++) step();
    check("pre_reset_audio_high", audio, 1);
    check("pre_reset_underrun", und, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_audio", audio, 0);
    check("async_ready", ready, 1);
    check("async_underrun", und, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      check("post_reset_pattern", audio, k & 1);
    end
    repeat (3 * DIV) step();
    check("post_reset_empty", und, 0);

    // Randomized traffic against the model, alternating bursty and sparse phases.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (((i / 500) % 2) == 0) valid = ($urandom_range(0, 2) == 0);
      else                      valid = ($urandom_range(0, 39) == 0);
      sample = W'($urandom);
      clear  = ($urandom_range(0, 63) == 0);
      step();
    end
    valid = 1'b0;
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
